fns_serial_encoder: RTL and testbench

- Sequential binary-to-Fibonacci Numeral System (FNS) encoder. It sits directly upstream of the Fibonacci adder chain in the CAC codec datapath.
- Accepts one binary word per transaction and produces a forbidden-pattern-free FNS codeword, meaning no two adjacent 1s.
- Uses a greedy MSB-first compare/subtract, one weight per clock.
- Weights step down the Fibonacci sequence with one subtractor instead of a ROM.

---
 rtl/fns_serial_encoder.sv | 180 ++++++++++++++++++
 tb/tb_fns_serial_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fns_serial_encoder.sv
// fns_serial_encoder
// Sequential binary-to-Fibonacci (FNS) encoder. Greedy MSB-first compare/subtract, one
// Fibonacci weight per clock. The weight pair steps down the sequence with one subtractor
// (Wa, Wb) <= (Wb, Wa - Wb), so no weight ROM is needed. Codewords never contain two
// adjacent 1s.
//
// Parameters:
//   DATA_W - binary input width
//   CODE_W - codeword width; bit i has weight w(i), w0=1, w1=2, wi=w(i-1)+w(i-2)
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_data   - binary value to encode
//   in_valid  - in_data valid
//   in_ready  - encoder idle, can accept
//   out_code  - FNS codeword (held while out_valid=1)
//   out_valid - out_code/out_err valid
//   out_ready - consumer accepts output
//   out_err   - input exceeded w(CODE_W)-1 (only with range check)
//
// Build option:
//   FNS_RANGE_CHECK_EN - when defined, words above w(CODE_W)-1 complete after one cycle with
//   out_code=0 and out_err=1. When undefined, out_err is tied low and such words are
//   encoded greedily into a truncated (still adjacency-free) codeword.
module fns_serial_encoder #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned CODE_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_err
);

  function automatic int unsigned fib_w(input int unsigned idx);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 2;
    if (idx == 0) return 1;
    for (int unsigned k = 1; k < idx; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam int unsigned MaxVal = fib_w(CODE_W) - 1;
  localparam int unsigned ValW   = $clog2(MaxVal + 1);
  localparam int unsigned RemW   = (DATA_W > ValW) ? DATA_W : ValW;
  localparam int unsigned CntW   = $clog2(CODE_W);

  localparam logic [RemW-1:0] WTop   = RemW'(fib_w(CODE_W - 1));
  localparam logic [RemW-1:0] WNext  = RemW'(fib_w(CODE_W - 2));
  localparam logic [CntW-1:0] CntTop = CntW'(CODE_W - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [RemW-1:0]   wa_q, wa_d;
  logic [RemW-1:0]   wb_q, wb_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              bit_take;

`ifdef FNS_RANGE_CHECK_EN
  logic out_err_q, out_err_d;
  logic over_range;
  assign over_range = (RemW'(in_data) > RemW'(MaxVal));
`endif

  // code_q[0] is the previously emitted bit; gating on it guarantees no adjacent 1s even
  // when the remainder is not below the current weight.
  assign bit_take = (rem_q >= wa_q) && !code_q[0];

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wa_d        = wa_q;
    wb_d        = wb_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef FNS_RANGE_CHECK_EN
    out_err_d   = out_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          rem_d      = RemW'(in_data);
          wa_d       = WTop;
          wb_d       = WNext;
          code_d     = '0;
          cnt_d      = CntTop;
          in_ready_d = 1'b0;
          state_d    = StBusy;
`ifdef FNS_RANGE_CHECK_EN
          out_err_d  = over_range;
          // Out-of-range: a single step on a zero remainder yields code 0 and reaches
          // DONE on the next edge.
          if (over_range) begin
            rem_d = '0;
            cnt_d = '0;
          end
`endif
        end
      end
      StBusy: begin
        code_d = {code_q[CODE_W-2:0], bit_take};
        if (bit_take) rem_d = rem_q - wa_q;
        wa_d = wb_q;
        wb_d = wa_q - wb_q;
        if (cnt_q == '0) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      wa_q        <= '0;
      wb_q        <= '0;
      cnt_q       <= '0;
      code_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef FNS_RANGE_CHECK_EN
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      wa_q        <= wa_d;
      wb_q        <= wb_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef FNS_RANGE_CHECK_EN
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = code_q;
`ifdef FNS_RANGE_CHECK_EN
  assign out_err   = out_err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fns_serial_encoder.sv
module tb_fns_serial_encoder;

  localparam int unsigned DATA_W = 9;
  localparam int unsigned CODE_W = 12;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_valid;
  logic              out_ready;
  logic              out_err;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned w [0:CODE_W];

  fns_serial_encoder #(.DATA_W(DATA_W), .CODE_W(CODE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit range_check_on();
`ifdef FNS_RANGE_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: Zeckendorf greedy on the integer value; every value above the range
  // collapses to the alternating pattern (or 0 when range checking rejects it).
  function automatic logic [CODE_W-1:0] model_code(input int unsigned v);
    logic [CODE_W-1:0] c;
    int unsigned r;
    c = '0;
    if (v > w[CODE_W] - 1) begin
      if (!range_check_on())
        for (int i = 1; i < CODE_W; i += 2) c[i] = 1'b1;
      return c;
    end
    r = v;
    for (int i = CODE_W - 1; i >= 0; i--)
      if (r >= w[i]) begin
        c[i] = 1'b1;
        r    = r - w[i];
      end
    return c;
  endfunction

  function automatic bit model_err(input int unsigned v);
    return range_check_on() && (v > w[CODE_W] - 1);
  endfunction

  function automatic int model_lat(input int unsigned v);
    return model_err(v) ? 1 : CODE_W;
  endfunction

  function automatic int unsigned code_value(input logic [CODE_W-1:0] c);
    int unsigned s = 0;
    for (int i = 0; i < CODE_W; i++) if (c[i]) s += w[i];
    return s;
  endfunction

  task automatic accept(input int unsigned v);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    in_data  = v[DATA_W-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
  endtask

  // Counts edges until out_valid is seen; lat = -1 on timeout.
  task automatic wait_valid(output int lat, output bit rdy_seen);
    lat      = 0;
    rdy_seen = 1'b0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) rdy_seen = 1'b1;
      if (out_valid) break;
      if (lat >= 40) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_code !== '0) $display("FAIL rst_out_code: got %h want 000", out_code); else n_pass++;
    n_checks++; if (out_err !== 1'b0) $display("FAIL rst_out_err: got %0b want 0", out_err); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL post_rst_idle: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_single(input int unsigned v, input string name);
    int lat;
    bit rs;
    logic [CODE_W-1:0] exp;
    exp = model_code(v);
    accept(v);
    wait_valid(lat, rs);
    n_checks++; if (lat !== model_lat(v)) $display("FAIL %s_latency: got %0d want %0d", name, lat, model_lat(v)); else n_pass++;
    n_checks++; if (out_code !== exp) $display("FAIL %s_code: got %h want %h", name, out_code, exp); else n_pass++;
    n_checks++; if (out_err !== model_err(v)) $display("FAIL %s_err: got %0b want %0b", name, out_err, model_err(v)); else n_pass++;
    n_checks++; if ((out_code & (out_code >> 1)) !== '0) $display("FAIL %s_fpf: got %h adjacent ones", name, out_code); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit rs;
    int unsigned vals [2] = '{255, 376};
    logic [CODE_W-1:0] req [2];
    req[0] = 12'h841;
    req[1] = 12'hAAA;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      accept(vals[i]);
      wait_valid(lat, rs);
      n_checks++; if (lat !== CODE_W) $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, CODE_W); else n_pass++;
      n_checks++; if (out_code !== req[i]) $display("FAIL b2b%0d_code: got %h want %h", i, out_code, req[i]); else n_pass++;
      n_checks++; if (rs !== 1'b0 || in_ready !== 1'b0) $display("FAIL b2b%0d_in_ready_busy: seen=%0b now=%0b want 0/0", i, rs, in_ready); else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL b2b_release: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat;
    bit rs;
    int bad = 0;
    out_ready = 1'b0;
    accept(255);
    wait_valid(lat, rs);
    n_checks++; if (lat !== CODE_W) $display("FAIL bp_latency: got %0d want %0d", lat, CODE_W); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_code !== 12'h841 || in_ready !== 1'b0) begin
        $display("FAIL bp_hold%0d: valid=%0b code=%h ready=%0b want 1/841/0", i, out_valid, out_code, in_ready);
        bad++;
      end else n_pass++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    bit rs;
    bit seen = 1'b0;
    out_ready = 1'b1;
    accept(200);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_code !== '0 || out_err !== 1'b0)
      $display("FAIL midrst_values: ready=%0b valid=%0b code=%h err=%0b want 1/0/000/0", in_ready, out_valid, out_code, out_err);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL midrst_no_valid: saw out_valid=%0b want 0", seen); else n_pass++;
    test_single(13, "after_rst_13");
    n_checks++; if (out_code !== 12'h020) $display("FAIL after_rst_13_const: got %h want 020", out_code); else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    bit rs;
    int unsigned v;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, (1 << DATA_W) - 1);
      accept(v);
      wait_valid(lat, rs);
      n_checks++; if (lat !== model_lat(v) || out_code !== model_code(v) || out_err !== model_err(v))
        $display("FAIL rand%0d v=%0d: lat=%0d code=%h err=%0b want %0d/%h/%0b", i, v, lat, out_code, out_err,
                 model_lat(v), model_code(v), model_err(v));
      else n_pass++;
      if (v <= w[CODE_W] - 1) begin
        n_checks++; if (code_value(out_code) !== v) $display("FAIL rand%0d_value: got %0d want %0d", i, code_value(out_code), v); else n_pass++;
      end
    end
  endtask

  initial begin
    w[0] = 1;
    w[1] = 2;
    for (int i = 2; i <= CODE_W; i++) w[i] = w[i-1] + w[i-2];
    test_reset();
    test_single(0, "zero");
    test_single(100, "v100");
    n_checks++; if (out_code !== 12'h214) $display("FAIL v100_const: got %h want 214", out_code); else n_pass++;
    test_back_to_back();
    test_backpressure();
    test_single(377, "v377");
    test_single(376, "v376");
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
